// File: rtl/bob_pkg.sv
// Shared core constants for the branch order buffer, fetch predictor and retire logic.
package bob_pkg;

    localparam int unsigned BOB_DEPTH  = 16;
    localparam int unsigned BOB_PTR_W  = $clog2(BOB_DEPTH);
    localparam int unsigned CORE_PC_W  = 64;
    localparam int unsigned CORE_GHR_W = 12;
    localparam int unsigned CORE_LHR_W = 10;

endpackage

// File: rtl/bob_ptr.sv
// Head/tail/count bookkeeping for the branch order buffer; wrap relies on power-of-two depth.
module bob_ptr #(
    parameter int unsigned PTR_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_i,
    input  logic             retire_i,
    input  logic             flush_i,
    output logic [PTR_W-1:0] head_o,
    output logic [PTR_W-1:0] tail_o,
    output logic [PTR_W:0]   count_o
);

    logic [PTR_W-1:0] head_d, head_q;
    logic [PTR_W-1:0] tail_d, tail_q;
    logic [PTR_W:0]   count_d, count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (retire_i) head_d = head_q + PTR_W'(1);
            if (alloc_i)  tail_d = tail_q + PTR_W'(1);
            count_d = count_q + (PTR_W+1)'(alloc_i) - (PTR_W+1)'(retire_i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;

endmodule

// File: rtl/bob.sv
// Branch order buffer: in-order FIFO of fetch prediction snapshots released at retire.
// Optional protocol checker enabled by defining BOB_CHK_EN.
module bob
    import bob_pkg::*;
#(
    parameter int unsigned DEPTH = BOB_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned PC_W  = CORE_PC_W,
    parameter int unsigned GHR_W = CORE_GHR_W,
    parameter int unsigned LHR_W = CORE_LHR_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_vld_i,
    input  logic [PC_W-1:0]  alloc_pc_i,
    input  logic [GHR_W-1:0] bpd_bhr_i,
    input  logic [LHR_W-1:0] bpd_bht_i,
    input  logic             bpd_ch_we_i,
    input  logic             bpd_ch_brdir_i,
    input  logic             retire_vld_i,
    input  logic             pipctl_flush_rt_i,
    output logic             bob_full_o,
    output logic             bob_empty_o,
    output logic [PTR_W-1:0] bob_alloc_id_o,
    output logic             bob_valid_r_o,
    output logic [PC_W-1:0]  bob_pc_r_o,
    output logic [GHR_W-1:0] bob_bhr_r_o,
    output logic [LHR_W-1:0] bob_lochist_o,
    output logic             bob_ch_we_o,
    output logic             bob_ch_brdir_o,
    output logic             bob_err_o
);

    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic             alloc_acc, retire_acc, head_vld;

    logic [DEPTH-1:0] valid_d, valid_q;
    logic [PC_W-1:0]  pc_mem_q  [DEPTH];
    logic [GHR_W-1:0] bhr_mem_q [DEPTH];
    logic [LHR_W-1:0] lhr_mem_q [DEPTH];
    logic [DEPTH-1:0] we_mem_q, dir_mem_q;

    assign bob_full_o  = count[PTR_W];
    assign bob_empty_o = (count == '0);
    assign alloc_acc   = alloc_vld_i & ~bob_full_o & ~pipctl_flush_rt_i;
    assign retire_acc  = retire_vld_i & ~bob_empty_o;

    bob_ptr #(
        .PTR_W (PTR_W)
    ) u_ptr (
        .clock    (clock),
        .reset    (reset),
        .alloc_i  (alloc_acc),
        .retire_i (retire_acc),
        .flush_i  (pipctl_flush_rt_i),
        .head_o   (head),
        .tail_o   (tail),
        .count_o  (count)
    );

    always_comb begin
        valid_d = valid_q;
        if (pipctl_flush_rt_i) begin
            valid_d = '0;
        end else begin
            if (retire_acc) valid_d[head] = 1'b0;
            if (alloc_acc)  valid_d[tail] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Payload needs no reset: reads are gated by the valid bit.
    always_ff @(posedge clock) begin
        if (alloc_acc) begin
            pc_mem_q[tail]  <= alloc_pc_i;
            bhr_mem_q[tail] <= bpd_bhr_i;
            lhr_mem_q[tail] <= bpd_bht_i;
            we_mem_q[tail]  <= bpd_ch_we_i;
            dir_mem_q[tail] <= bpd_ch_brdir_i;
        end
    end

    assign head_vld       = valid_q[head];
    assign bob_alloc_id_o = tail;
    assign bob_valid_r_o  = ~bob_empty_o;
    assign bob_pc_r_o     = head_vld ? pc_mem_q[head]  : '0;
    assign bob_bhr_r_o    = head_vld ? bhr_mem_q[head] : '0;
    assign bob_lochist_o  = head_vld ? lhr_mem_q[head] : '0;
    assign bob_ch_we_o    = head_vld & we_mem_q[head];
    assign bob_ch_brdir_o = head_vld & dir_mem_q[head];

`ifdef BOB_CHK_EN
    logic err_d, err_q;

    always_comb begin
        err_d = err_q | (alloc_vld_i & bob_full_o) | (retire_vld_i & bob_empty_o)
              | (retire_vld_i & ~head_vld);
    end

    always_ff @(posedge clock) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign bob_err_o = err_q;
`else
    assign bob_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bob.sv
// Randomized self-checking bench for bob against a queue-based reference model.
module tb_bob;

    typedef struct {
        logic [63:0] pc;
        logic [11:0] bhr;
        logic [9:0]  bht;
        logic        we;
        logic        dir;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        alloc_vld_i;
    logic [63:0] alloc_pc_i;
    logic [11:0] bpd_bhr_i;
    logic [9:0]  bpd_bht_i;
    logic        bpd_ch_we_i, bpd_ch_brdir_i, retire_vld_i, pipctl_flush_rt_i;
    logic        bob_full_o, bob_empty_o, bob_valid_r_o, bob_ch_we_o, bob_ch_brdir_o, bob_err_o;
    logic [3:0]  bob_alloc_id_o;
    logic [63:0] bob_pc_r_o;
    logic [11:0] bob_bhr_r_o;
    logic [9:0]  bob_lochist_o;

    int n_chk  = 0;
    int n_pass = 0;

    ent_t q[$];
    int   m_tail = 0;
    bit   m_err  = 0;
    bit   chk_on = 0;

    always #5 clock = ~clock;

    bob u_dut (
        .clock             (clock),
        .reset             (reset),
        .alloc_vld_i       (alloc_vld_i),
        .alloc_pc_i        (alloc_pc_i),
        .bpd_bhr_i         (bpd_bhr_i),
        .bpd_bht_i         (bpd_bht_i),
        .bpd_ch_we_i       (bpd_ch_we_i),
        .bpd_ch_brdir_i    (bpd_ch_brdir_i),
        .retire_vld_i      (retire_vld_i),
        .pipctl_flush_rt_i (pipctl_flush_rt_i),
        .bob_full_o        (bob_full_o),
        .bob_empty_o       (bob_empty_o),
        .bob_alloc_id_o    (bob_alloc_id_o),
        .bob_valid_r_o     (bob_valid_r_o),
        .bob_pc_r_o        (bob_pc_r_o),
        .bob_bhr_r_o       (bob_bhr_r_o),
        .bob_lochist_o     (bob_lochist_o),
        .bob_ch_we_o       (bob_ch_we_o),
        .bob_ch_brdir_o    (bob_ch_brdir_o),
        .bob_err_o         (bob_err_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a plain queue of live entries, updated from the sampled inputs.
    always @(posedge clock) begin
        bit full, empty;
        full  = (q.size() == 16);
        empty = (q.size() == 0);
        if (reset) begin
            q.delete();
            m_tail = 0;
            m_err  = 0;
            chk_on = 1;
        end else begin
            if ((alloc_vld_i && full) || (retire_vld_i && empty)) m_err = 1;
            if (pipctl_flush_rt_i) begin
                q.delete();
                m_tail = 0;
            end else begin
                if (retire_vld_i && !empty) void'(q.pop_front());
                if (alloc_vld_i && !full) begin
                    q.push_back('{alloc_pc_i, bpd_bhr_i, bpd_bht_i, bpd_ch_we_i, bpd_ch_brdir_i});
                    m_tail = (m_tail + 1) % 16;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            ent_t h;
            h = '{64'h0, 12'h0, 10'h0, 1'b0, 1'b0};
            if (q.size() != 0) h = q[0];
            check("empty", 64'(bob_empty_o), 64'(q.size() == 0));
            check("full", 64'(bob_full_o), 64'(q.size() == 16));
            check("valid_r", 64'(bob_valid_r_o), 64'(q.size() != 0));
            check("alloc_id", 64'(bob_alloc_id_o), 64'(m_tail));
            check("pc_r", bob_pc_r_o, h.pc);
            check("bhr_r", 64'(bob_bhr_r_o), 64'(h.bhr));
            check("lochist", 64'(bob_lochist_o), 64'(h.bht));
            check("ch_we", 64'(bob_ch_we_o), 64'(h.we));
            check("ch_brdir", 64'(bob_ch_brdir_o), 64'(h.dir));
`ifdef BOB_CHK_EN
            check("err", 64'(bob_err_o), 64'(m_err));
`else
            check("err", 64'(bob_err_o), 64'h0);
`endif
        end
    end

    // Drive one cycle of inputs after a negedge; returns at the following negedge.
    task automatic cyc(input bit a, input logic [63:0] pc, input logic [11:0] bhr,
                       input logic [9:0] bht, input bit we, input bit dir,
                       input bit r, input bit f, input bit rst = 0);
        reset = rst; alloc_vld_i = a; alloc_pc_i = pc; bpd_bhr_i = bhr; bpd_bht_i = bht;
        bpd_ch_we_i = we; bpd_ch_brdir_i = dir; retire_vld_i = r; pipctl_flush_rt_i = f;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic alloc(input logic [63:0] pc, input logic [11:0] bhr);
        cyc(1, pc, bhr, 10'(pc), pc[0], pc[1], 0, 0);
    endtask

    task automatic retire();
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        reset = 1; alloc_vld_i = 0; alloc_pc_i = 0; bpd_bhr_i = 0; bpd_bht_i = 0;
        bpd_ch_we_i = 0; bpd_ch_brdir_i = 0; retire_vld_i = 0; pipctl_flush_rt_i = 0;
        @(negedge clock);
        do_reset();
        do_reset();

        // Reset then idle
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("lit_rst_empty", 64'(bob_empty_o), 64'h1);
        check("lit_rst_full", 64'(bob_full_o), 64'h0);
        check("lit_rst_valid", 64'(bob_valid_r_o), 64'h0);
        check("lit_rst_pc", bob_pc_r_o, 64'h0);
        check("lit_rst_err", 64'(bob_err_o), 64'h0);

        // Single entry round trip
        cyc(1, 64'h1000, 12'hABC, 10'h155, 1, 0, 0, 0);
        check("lit_one_valid", 64'(bob_valid_r_o), 64'h1);
        check("lit_one_pc", bob_pc_r_o, 64'h1000);
        check("lit_one_bhr", 64'(bob_bhr_r_o), 64'hABC);
        check("lit_one_lhr", 64'(bob_lochist_o), 64'h155);
        check("lit_one_we", 64'(bob_ch_we_o), 64'h1);
        check("lit_one_dir", 64'(bob_ch_brdir_o), 64'h0);
        retire();
        check("lit_one_empty", 64'(bob_empty_o), 64'h1);

        // Fill, overflow, drain, wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            check("lit_fill_id", 64'(bob_alloc_id_o), 64'(i));
            alloc(64'h100 + 64'(4 * i), 12'(i));
        end
        check("lit_fill_full", 64'(bob_full_o), 64'h1);
        alloc(64'hDEAD, 12'h0);
        check("lit_drop_full", 64'(bob_full_o), 64'h1);
        check("lit_drop_id", 64'(bob_alloc_id_o), 64'h0);
        for (int i = 0; i < 16; i++) begin
            check("lit_drain_pc", bob_pc_r_o, 64'h100 + 64'(4 * i));
            retire();
        end
        for (int i = 0; i < 3; i++) begin
            alloc(64'h200 + 64'(i), 12'h0);
            check("lit_wrap_pc", bob_pc_r_o, 64'h200 + 64'(i));
            retire();
        end
        check("lit_wrap_id", 64'(bob_alloc_id_o), 64'h3);

        // Simultaneous alloc+retire, incl. at full
        do_reset();
        for (int i = 0; i < 5; i++) alloc(64'h300 + 64'(i), 12'h0);
        cyc(1, 64'h305, 0, 0, 0, 0, 1, 0);
        check("lit_ar_id", 64'(bob_alloc_id_o), 64'h6);
        check("lit_ar_pc", bob_pc_r_o, 64'h301);
        for (int i = 0; i < 11; i++) alloc(64'h306 + 64'(i), 12'h0);
        check("lit_ar_full", 64'(bob_full_o), 64'h1);
        cyc(1, 64'hBAD, 0, 0, 0, 0, 1, 0);
        check("lit_ar_notfull", 64'(bob_full_o), 64'h0);

        // Flush with retire+alloc
        do_reset();
        for (int i = 0; i < 7; i++) alloc(64'h400 + 64'(i), 12'h10 + 12'(i));
        reset = 0; alloc_vld_i = 1; alloc_pc_i = 64'h999; retire_vld_i = 1; pipctl_flush_rt_i = 1;
        #1;
        check("lit_fl_bhr", 64'(bob_bhr_r_o), 64'h10);
        @(posedge clock);
        @(negedge clock);
        check("lit_fl_empty", 64'(bob_empty_o), 64'h1);
        check("lit_fl_id", 64'(bob_alloc_id_o), 64'h0);
        check("lit_fl_pc", bob_pc_r_o, 64'h0);

        // Retire on empty
        retire();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
`ifdef BOB_CHK_EN
        check("lit_err_sticky", 64'(bob_err_o), 64'h1);
        do_reset();
        check("lit_err_clear", 64'(bob_err_o), 64'h0);
`else
        check("lit_err_tied", 64'(bob_err_o), 64'h0);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit a, r, f, rs;
            a  = ($urandom_range(99) < 60);
            r  = ($urandom_range(99) < 50);
            f  = ($urandom_range(99) < 3);
            rs = ($urandom_range(999) < 5);
            cyc(a, {$urandom, $urandom}, 12'($urandom), 10'($urandom), 1'($urandom),
                1'($urandom), r, f, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
